// File: rtl/pmod_jd_pkg.sv
// Shared constants and types for the PMOD JD output pacer.
package pmod_jd_pkg;
  localparam int JD_W = 8;

  typedef enum logic {IDLE, HOLD} jd_state_e;
endpackage

// File: rtl/pmod_jd_fifo.sv
// Generic synchronous FIFO. Occupancy is kept as a registered count.
// A push while full is still taken when a pop frees a slot in the same cycle.
module pmod_jd_fifo
  import pmod_jd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = JD_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [WIDTH-1:0]           head
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (level == LVL_W'(DEPTH));
    empty   = (level == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head    = mem[rd_ptr];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data;
  end
endmodule

// File: rtl/pmod_jd_pacer.sv
// PMOD JD output stage: buffers single-cycle byte strobes and holds each byte
// on the pins for HOLD_CYCLES clocks, back-to-back without gaps.
module pmod_jd_pacer
  import pmod_jd_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 5000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       write_i,
  input  logic [JD_W-1:0]            write_data_i,
  output logic [JD_W-1:0]            jd_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       overflow_o
);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

  jd_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic [JD_W-1:0]  fifo_head;
  logic             pop;
  logic             push;
  logic             drop;

  // A byte leaves the FIFO whenever the pins are free: idle, or the hold just expired.
  always_comb begin
    pop    = !fifo_empty && ((state == IDLE) || (cnt == '0));
    push   = write_i && (!fifo_full || pop);
    drop   = write_i && fifo_full && !pop;
    busy_o = (state == HOLD) || (level_o != '0);
  end

  pmod_jd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (JD_W)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .data  (write_data_i),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o),
    .head  (fifo_head)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      jd_o       <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (drop) overflow_o <= 1'b1;
      case (state)
        IDLE: begin
          if (pop) begin
            jd_o  <= fifo_head;
            cnt   <= CNT_RELOAD;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (pop) begin
            jd_o <= fifo_head;
            cnt  <= CNT_RELOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pmod_jd_pacer.sv
// Scoreboard bench for pmod_jd_pacer: one instance with HOLD_CYCLES=4, one with 1.
`timescale 1ns/1ps
module tb_pmod_jd_pacer;
  localparam int DEPTH  = 4;
  localparam int HOLD_A = 4;
  localparam int HOLD_B = 1;

  typedef struct {
    logic [7:0] data;
    int         edge_n;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_a = 1'b0, wr_b = 1'b0;
  logic [7:0] wd_a = 8'h00, wd_b = 8'h00;
  logic [7:0] jd_a, jd_b;
  logic       busy_a, busy_b, ov_a, ov_b;
  logic [2:0] lvl_a, lvl_b;

  int   checks = 0;
  int   failures = 0;
  int   ecnt = 0;
  int   last_a = -1000;
  int   last_b = -1000;
  exp_t q_a[$];
  exp_t q_b[$];
  logic [7:0] prev_a = 8'h00, prev_b = 8'h00;

  always #5 clk = ~clk;

  pmod_jd_pacer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD_A)) dut_a (
    .clk_i(clk), .rst_i(rst), .write_i(wr_a), .write_data_i(wd_a),
    .jd_o(jd_a), .busy_o(busy_a), .level_o(lvl_a), .overflow_o(ov_a)
  );

  pmod_jd_pacer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD_B)) dut_b (
    .clk_i(clk), .rst_i(rst), .write_i(wr_b), .write_data_i(wd_b),
    .jd_o(jd_b), .busy_o(busy_b), .level_o(lvl_b), .overflow_o(ov_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, ecnt);
    end
  endtask

  // Edge counter: edge n ends cycle n-1 after reset release.
  always @(posedge clk) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (rst) begin
      prev_a = jd_a;
      prev_b = jd_b;
    end else begin
      if (jd_a !== prev_a) begin
        if (q_a.size() == 0) chk("a_unexpected", {24'h0, jd_a}, {24'h0, prev_a});
        else begin
          e = q_a.pop_front();
          chk("a_data", {24'h0, jd_a}, {24'h0, e.data});
          chk("a_edge", ecnt, e.edge_n);
        end
        prev_a = jd_a;
      end
      if (jd_b !== prev_b) begin
        if (q_b.size() == 0) chk("b_unexpected", {24'h0, jd_b}, {24'h0, prev_b});
        else begin
          e = q_b.pop_front();
          chk("b_data", {24'h0, jd_b}, {24'h0, e.data});
          chk("b_edge", ecnt, e.edge_n);
        end
        prev_b = jd_b;
      end
    end
  end

  task automatic reset_all(input int n);
    @(negedge clk);
    rst = 1'b1; wr_a = 1'b0; wr_b = 1'b0;
    q_a.delete(); q_b.delete();
    last_a = -1000; last_b = -1000;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Emission edge: two edges after the write, but never before the previous byte's hold ends.
  task automatic put_a(input logic [7:0] d, input bit acc);
    exp_t e;
    wr_a = 1'b1; wd_a = d;
    if (acc) begin
      e.data   = d;
      e.edge_n = (ecnt + 2 > last_a + HOLD_A) ? ecnt + 2 : last_a + HOLD_A;
      last_a   = e.edge_n;
      q_a.push_back(e);
    end
    @(negedge clk);
    wr_a = 1'b0;
  endtask

  task automatic put_b(input logic [7:0] d);
    exp_t e;
    wr_b = 1'b1; wd_b = d;
    e.data   = d;
    e.edge_n = (ecnt + 2 > last_b + HOLD_B) ? ecnt + 2 : last_b + HOLD_B;
    last_b   = e.edge_n;
    q_b.push_back(e);
    @(negedge clk);
    wr_b = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((q_a.size() + q_b.size()) != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q_a.size() + q_b.size(), 0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int peak;

    // Reset and idle
    reset_all(3);
    for (int c = 0; c < 10; c++) begin
      chk("t1_jd", {24'h0, jd_a}, 32'h00);
      chk("t1_busy", {31'h0, busy_a}, 32'h0);
      chk("t1_level", {29'h0, lvl_a}, 32'h0);
      chk("t1_ovf", {31'h0, ov_a}, 32'h0);
      @(negedge clk);
    end

    // Single byte
    reset_all(2);
    put_a(8'hA5, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      chk("t2_busy", {31'h0, busy_a}, {31'h0, (c <= 5)});
      @(negedge clk);
    end
    chk("t2_jd_hold", {24'h0, jd_a}, 32'hA5);
    drain(20);

    // Four back-to-back bytes
    reset_all(2);
    peak = 0;
    for (int i = 1; i <= 4; i++) begin
      put_a(8'(i), 1'b1);
      if (int'(lvl_a) > peak) peak = int'(lvl_a);
    end
    for (int c = 0; c < 16; c++) begin
      if (int'(lvl_a) > peak) peak = int'(lvl_a);
      @(negedge clk);
    end
    chk("t3_peak", peak, 3);
    chk("t3_ovf", {31'h0, ov_a}, 32'h0);
    drain(30);

    // Overflow: 06 taken on a simultaneous push/pop, 07 dropped
    reset_all(2);
    for (int i = 1; i <= 6; i++) put_a(8'(i), 1'b1);
    chk("t4_ovf_before", {31'h0, ov_a}, 32'h0);
    chk("t4_level_full", {29'h0, lvl_a}, 32'h4);
    put_a(8'h07, 1'b0);
    chk("t4_ovf_after", {31'h0, ov_a}, 32'h1);
    drain(60);
    chk("t4_ovf_sticky", {31'h0, ov_a}, 32'h1);
    chk("t4_last_jd", {24'h0, jd_a}, 32'h06);

    // Reset mid-hold flushes pending bytes
    reset_all(2);
    chk("t5_ovf_cleared", {31'h0, ov_a}, 32'h0);
    put_a(8'h11, 1'b1);
    put_a(8'h22, 1'b1);
    put_a(8'h33, 1'b1);
    @(negedge clk);
    chk("t5_jd_pre", {24'h0, jd_a}, 32'h11);
    rst = 1'b1;
    q_a.delete();
    last_a = -1000;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_jd_rst", {24'h0, jd_a}, 32'h00);
    chk("t5_level_rst", {29'h0, lvl_a}, 32'h0);
    chk("t5_busy_rst", {31'h0, busy_a}, 32'h0);
    repeat (20) @(negedge clk);
    chk("t5_jd_quiet", {24'h0, jd_a}, 32'h00);

    // HOLD_CYCLES=1: one byte per cycle
    reset_all(2);
    put_b(8'h0A);
    put_b(8'h0B);
    put_b(8'h0C);
    @(negedge clk);
    chk("t6_busy4", {31'h0, busy_b}, 32'h1);
    @(negedge clk);
    chk("t6_busy5", {31'h0, busy_b}, 32'h0);
    chk("t6_jd", {24'h0, jd_b}, 32'h0C);
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
